// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Two byte requesters share one UART TX FIFO write channel. The channel is
// held by whichever requester sent a byte until that requester sends the
// end-of-line byte or stays silent for `timeout` cycles. This keeps each
// message contiguous on the wire. The output byte/valid pair is registered.
module uart_tx_arbiter #(
    parameter int                    data_width = 8,
    parameter logic [data_width-1:0] eol        = data_width'(8'h0A),
    parameter int                    timeout    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] r0_wdata,
    input  logic                  r0_wvalid,
    output logic                  r0_wready,
    input  logic [data_width-1:0] r1_wdata,
    input  logic                  r1_wvalid,
    output logic                  r1_wready,
    output logic [data_width-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    output logic                  owner,
    output logic                  locked,
    output logic                  tmo
);

    // Idle counter must be able to hold values up to timeout-1.
    localparam int cnt_w = $clog2(timeout + 1);
    localparam logic [cnt_w-1:0] tmo_last = cnt_w'(timeout - 1);

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_lock0 = 2'd1,
        st_lock1 = 2'd2
    } state_t;

    state_t              state_r;
    logic                last_r;     // requester that most recently finished a message
    logic [cnt_w-1:0]    cnt_r;      // idle cycles of the lock holder

    logic                slot_free_s;
    logic                g0_s;
    logic                g1_s;
    logic                win0_s;
    logic                acc0_s;
    logic                acc1_s;
    logic                acc_any_s;
    logic                acc_id_s;
    logic [data_width-1:0] acc_byte_s;
    logic                acc_eol_s;
    logic                own_valid_s;
    logic                tmo_hit_s;

    // Output slot availability: empty, or the FIFO takes the byte this cycle.
    always_comb begin
        slot_free_s = ~wvalid | wready;
    end

    // Grant selection: round-robin tie-break in IDLE, fixed grant while locked.
    always_comb begin
        g0_s   = 1'b0;
        g1_s   = 1'b0;
        win0_s = r0_wvalid & (~r1_wvalid | last_r);
        case (state_r)
            st_idle: begin
                g0_s = win0_s;
                g1_s = r1_wvalid & ~win0_s;
            end
            st_lock0: begin
                g0_s = 1'b1;
                g1_s = 1'b0;
            end
            st_lock1: begin
                g0_s = 1'b0;
                g1_s = 1'b1;
            end
            default: begin
                g0_s = 1'b0;
                g1_s = 1'b0;
            end
        endcase
    end

    // Upstream ready does not look at the requester's own valid; it is
    // forced low while reset is asserted so nothing is taken during reset.
    always_comb begin
        r0_wready = g0_s & slot_free_s & rst;
        r1_wready = g1_s & slot_free_s & rst;
    end

    // Accept decode: at most one grant is ever high, so at most one accept.
    always_comb begin
        acc0_s    = r0_wvalid & r0_wready;
        acc1_s    = r1_wvalid & r1_wready;
        acc_any_s = acc0_s | acc1_s;
        acc_id_s  = acc1_s;
        if (acc1_s) begin
            acc_byte_s = r1_wdata;
        end else begin
            acc_byte_s = r0_wdata;
        end
        acc_eol_s = acc_any_s & (acc_byte_s == eol);
    end

    // Timeout condition: lock holder silent and the idle count at its limit.
    always_comb begin
        case (state_r)
            st_lock0: own_valid_s = r0_wvalid;
            st_lock1: own_valid_s = r1_wvalid;
            default:  own_valid_s = 1'b0;
        endcase
        if ((state_r == st_lock0) || (state_r == st_lock1)) begin
            tmo_hit_s = ~acc_any_s & ~own_valid_s & (cnt_r == tmo_last);
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Arbitration FSM together with the registered output byte and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= st_idle;
            last_r  <= 1'b1;
            cnt_r   <= '0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            owner   <= 1'b0;
            locked  <= 1'b0;
            tmo     <= 1'b0;
        end else begin
            tmo <= 1'b0;

            if (slot_free_s) begin
                wvalid <= acc_any_s;
                if (acc_any_s) begin
                    wdata <= acc_byte_s;
                end else begin
                    wdata <= wdata;
                end
            end else begin
                wvalid <= wvalid;
                wdata  <= wdata;
            end

            if (acc_any_s) begin
                owner <= acc_id_s;
            end else begin
                owner <= owner;
            end

            case (state_r)
                st_idle: begin
                    cnt_r <= '0;
                    if (acc_any_s && acc_eol_s) begin
                        last_r <= acc_id_s;
                    end else if (acc_any_s) begin
                        state_r <= acc_id_s ? st_lock1 : st_lock0;
                        locked  <= 1'b1;
                    end else begin
                        state_r <= st_idle;
                    end
                end
                st_lock0, st_lock1: begin
                    if (acc_eol_s) begin
                        state_r <= st_idle;
                        locked  <= 1'b0;
                        last_r  <= acc_id_s;
                        cnt_r   <= '0;
                    end else if (acc_any_s) begin
                        cnt_r <= '0;
                    end else if (tmo_hit_s) begin
                        state_r <= st_idle;
                        locked  <= 1'b0;
                        last_r  <= (state_r == st_lock1);
                        tmo     <= 1'b1;
                        cnt_r   <= '0;
                    end else if (!own_valid_s) begin
                        cnt_r <= cnt_r + cnt_w'(1);
                    end else begin
                        // Holder still has a byte pending behind a busy slot.
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r <= st_idle;
                    locked  <= 1'b0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule
